upb_outport_filter: RTL and testbench

UPB_OUTPORT_FILTER -- requirements
Module: upb_outport_filter

---
 rtl/upb_outport_filter_pkg.sv | 35 +++
 rtl/axis_skid_buf.sv | 51 +++++
 rtl/upb_outport_filter.sv | 125 ++++++++++++
 tb/tb_upb_outport_filter.sv | 478 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/upb_outport_filter_pkg.sv
// Shared types for the output-port filter: FSM states, sideband widths and the
// packed beat carried through the output skid buffer.
package upb_outport_filter_pkg;

   localparam int DATA_W    = 256;
   localparam int KEEP_W    = 32;
   localparam int IN_PORT_W = 3;
   localparam int PORT_W    = 8;
   localparam int LEN_W     = 14;

   typedef enum logic [1:0] {
      HEAD = 2'd0,
      PASS = 2'd1,
      DROP = 2'd2
   } state_t;

   typedef struct packed {
      logic [DATA_W-1:0]    tdata;
      logic [KEEP_W-1:0]    tkeep;
      logic                 tlast;
      logic [IN_PORT_W-1:0] in_port;
      logic [IN_PORT_W-1:0] in_vport;
      logic [PORT_W-1:0]    out_port;
      logic [PORT_W-1:0]    out_vport;
      logic [LEN_W-1:0]     packet_length;
   } beat_t;

   // One-hot mask of the DMA port bit; an id outside 0..7 yields no bit at all.
   function automatic logic [PORT_W-1:0] dma_mask(input int id);
      logic [2:0] idx;
      idx = id[2:0];
      dma_mask = (id >= 0 && id < PORT_W) ? (8'h01 << idx) : 8'h00;
   endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-stream skid buffer: registered output stage plus one overflow
// slot, so in_ready is a flop and throughput stays at one beat per cycle.
module axis_skid_buf #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         resetn,
   input  logic [W-1:0] in_data,
   input  logic         in_valid,
   output logic         in_ready,
   output logic [W-1:0] out_data,
   output logic         out_valid,
   input  logic         out_ready
);

   logic [W-1:0] skid_data;
   logic         skid_valid;
   logic         push;
   logic         load;

   assign push = in_valid && in_ready;
   assign load = out_ready || !out_valid;

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         out_data   <= '0;
         out_valid  <= 1'b0;
         skid_data  <= '0;
         skid_valid <= 1'b0;
         in_ready   <= 1'b0;
      end else if (load) begin
         // in_ready was low whenever the skid slot is occupied, so no push can collide here
         if (skid_valid) begin
            out_data  <= skid_data;
            out_valid <= 1'b1;
         end else begin
            out_valid <= push;
            if (push) out_data <= in_data;
         end
         skid_valid <= 1'b0;
         in_ready   <= 1'b1;
      end else if (push) begin
         skid_data  <= in_data;
         skid_valid <= 1'b1;
         in_ready   <= 1'b0;
      end else begin
         in_ready <= !skid_valid;
      end
   end

endmodule

// File: rtl/upb_outport_filter.sv
// Output-port filter: masks each packet's destination ports at its head beat,
// forwards or discards the whole packet, and counts both outcomes.
module upb_outport_filter
   import upb_outport_filter_pkg::*;
#(
   parameter int dma_port_id = 999,
   parameter int CNT_WIDTH   = 32
) (
   input  logic                 clk,
   input  logic                 resetn,
   input  logic [255:0]         s_axis_tdata,
   input  logic [31:0]          s_axis_tkeep,
   input  logic                 s_axis_tvalid,
   input  logic                 s_axis_tlast,
   input  logic [2:0]           s_axis_tuser_in_port,
   input  logic [2:0]           s_axis_tuser_in_vport,
   input  logic [7:0]           s_axis_tuser_out_port,
   input  logic [7:0]           s_axis_tuser_out_vport,
   input  logic [13:0]          s_axis_tuser_packet_length,
   output logic                 s_axis_tready,
   output logic [255:0]         m_axis_tdata,
   output logic [31:0]          m_axis_tkeep,
   output logic                 m_axis_tvalid,
   output logic                 m_axis_tlast,
   output logic [2:0]           m_axis_tuser_in_port,
   output logic [2:0]           m_axis_tuser_in_vport,
   output logic [7:0]           m_axis_tuser_out_port,
   output logic [7:0]           m_axis_tuser_out_vport,
   output logic [13:0]          m_axis_tuser_packet_length,
   input  logic                 m_axis_tready,
   input  logic [7:0]           port_enable,
   input  logic [7:0]           vport_enable,
   output logic [CNT_WIDTH-1:0] pass_count,
   output logic [CNT_WIDTH-1:0] drop_count,
   output logic [1:0]           fsm_state
);

   localparam logic [7:0] DMA_MASK = dma_mask(dma_port_id);

   state_t     state;
   logic [7:0] lat_port;
   logic [7:0] lat_vport;
   logic [7:0] head_port;
   logic [7:0] head_vport;
   logic       head_drop;
   logic       accept;
   logic       fwd_valid;
   logic       buf_ready;
   beat_t      in_beat;
   beat_t      out_beat;

   always_comb begin
      head_vport = s_axis_tuser_out_vport & vport_enable;
      head_port  = s_axis_tuser_out_port & port_enable;
      // A DMA destination with no enabled vport has nowhere to go
      if ((head_port & DMA_MASK) != 8'h00 && head_vport == 8'h00)
         head_port = head_port & ~DMA_MASK;
      head_drop = (head_port == 8'h00);
   end

   assign s_axis_tready = (state == DROP) || buf_ready;
   assign accept        = s_axis_tvalid && s_axis_tready;
   assign fwd_valid     = s_axis_tvalid &&
                          ((state == PASS) || (state == HEAD && !head_drop));
   assign fsm_state     = state;

   always_comb begin
      in_beat.tdata         = s_axis_tdata;
      in_beat.tkeep         = s_axis_tkeep;
      in_beat.tlast         = s_axis_tlast;
      in_beat.in_port       = s_axis_tuser_in_port;
      in_beat.in_vport      = s_axis_tuser_in_vport;
      in_beat.packet_length = s_axis_tuser_packet_length;
      in_beat.out_port      = (state == HEAD) ? head_port : lat_port;
      in_beat.out_vport     = (state == HEAD) ? head_vport : lat_vport;
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= HEAD;
         lat_port   <= 8'h00;
         lat_vport  <= 8'h00;
         pass_count <= '0;
         drop_count <= '0;
      end else if (accept) begin
         case (state)
            HEAD: begin
               if (head_drop) begin
                  if (drop_count != {CNT_WIDTH{1'b1}}) drop_count <= drop_count + 1'b1;
                  state <= s_axis_tlast ? HEAD : DROP;
               end else begin
                  lat_port  <= head_port;
                  lat_vport <= head_vport;
                  if (pass_count != {CNT_WIDTH{1'b1}}) pass_count <= pass_count + 1'b1;
                  state <= s_axis_tlast ? HEAD : PASS;
               end
            end
            PASS:    if (s_axis_tlast) state <= HEAD;
            DROP:    if (s_axis_tlast) state <= HEAD;
            default: state <= HEAD;
         endcase
      end
   end

   axis_skid_buf #(.W($bits(beat_t))) u_skid (
      .clk       (clk),
      .resetn    (resetn),
      .in_data   (in_beat),
      .in_valid  (fwd_valid),
      .in_ready  (buf_ready),
      .out_data  (out_beat),
      .out_valid (m_axis_tvalid),
      .out_ready (m_axis_tready)
   );

   assign m_axis_tdata               = out_beat.tdata;
   assign m_axis_tkeep               = out_beat.tkeep;
   assign m_axis_tlast               = out_beat.tlast;
   assign m_axis_tuser_in_port       = out_beat.in_port;
   assign m_axis_tuser_in_vport      = out_beat.in_vport;
   assign m_axis_tuser_out_port      = out_beat.out_port;
   assign m_axis_tuser_out_vport     = out_beat.out_vport;
   assign m_axis_tuser_packet_length = out_beat.packet_length;

endmodule

// File: tb/tb_upb_outport_filter.sv
// Directed bench for upb_outport_filter (DMA port 1, 8-bit counters): pass, drop,
// DMA vport rule, random backpressure, enable changes, mid-packet reset, saturation.
module tb_upb_outport_filter;

   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          resetn = 1'b0;
   logic [255:0]  s_axis_tdata = '0;
   logic [31:0]   s_axis_tkeep = '0;
   logic          s_axis_tvalid = 1'b0;
   logic          s_axis_tlast = 1'b0;
   logic [2:0]    s_axis_tuser_in_port = '0;
   logic [2:0]    s_axis_tuser_in_vport = '0;
   logic [7:0]    s_axis_tuser_out_port = '0;
   logic [7:0]    s_axis_tuser_out_vport = '0;
   logic [13:0]   s_axis_tuser_packet_length = '0;
   logic          s_axis_tready;
   logic [255:0]  m_axis_tdata;
   logic [31:0]   m_axis_tkeep;
   logic          m_axis_tvalid;
   logic          m_axis_tlast;
   logic [2:0]    m_axis_tuser_in_port;
   logic [2:0]    m_axis_tuser_in_vport;
   logic [7:0]    m_axis_tuser_out_port;
   logic [7:0]    m_axis_tuser_out_vport;
   logic [13:0]   m_axis_tuser_packet_length;
   logic          m_axis_tready = 1'b1;
   logic [7:0]    port_enable = 8'hFF;
   logic [7:0]    vport_enable = 8'hFF;
   logic [CW-1:0] pass_count;
   logic [CW-1:0] drop_count;
   logic [1:0]    fsm_state;

   int checks = 0;
   int errors = 0;
   int cyc = 0;

   typedef struct {
      logic [255:0] data;
      logic [31:0]  keep;
      logic         last;
      logic [2:0]   inp;
      logic [2:0]   invp;
      logic [13:0]  len;
      logic [7:0]   op;
      logic [7:0]   ov;
      int           cyc;
   } rec_t;

   rec_t        got_q[$];
   logic [31:0] exp_q[$];

   upb_outport_filter #(.dma_port_id(1), .CNT_WIDTH(CW)) dut (
      .clk                        (clk),
      .resetn                     (resetn),
      .s_axis_tdata               (s_axis_tdata),
      .s_axis_tkeep               (s_axis_tkeep),
      .s_axis_tvalid              (s_axis_tvalid),
      .s_axis_tlast               (s_axis_tlast),
      .s_axis_tuser_in_port       (s_axis_tuser_in_port),
      .s_axis_tuser_in_vport      (s_axis_tuser_in_vport),
      .s_axis_tuser_out_port      (s_axis_tuser_out_port),
      .s_axis_tuser_out_vport     (s_axis_tuser_out_vport),
      .s_axis_tuser_packet_length (s_axis_tuser_packet_length),
      .s_axis_tready              (s_axis_tready),
      .m_axis_tdata               (m_axis_tdata),
      .m_axis_tkeep               (m_axis_tkeep),
      .m_axis_tvalid              (m_axis_tvalid),
      .m_axis_tlast               (m_axis_tlast),
      .m_axis_tuser_in_port       (m_axis_tuser_in_port),
      .m_axis_tuser_in_vport      (m_axis_tuser_in_vport),
      .m_axis_tuser_out_port      (m_axis_tuser_out_port),
      .m_axis_tuser_out_vport     (m_axis_tuser_out_vport),
      .m_axis_tuser_packet_length (m_axis_tuser_packet_length),
      .m_axis_tready              (m_axis_tready),
      .port_enable                (port_enable),
      .vport_enable               (vport_enable),
      .pass_count                 (pass_count),
      .drop_count                 (drop_count),
      .fsm_state                  (fsm_state)
   );

   // clock / reset block
   always #5 clk = ~clk;
   always @(posedge clk) cyc++;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d", checks, errors);
      $fatal(1, "watchdog");
   end

   // output monitor: records every transfer and checks hold-while-stalled
   logic         stalled_prev = 1'b0;
   logic [255:0] prev_data;
   logic [7:0]   prev_port;
   always begin
      rec_t r;
      @(negedge clk);
      #2;
      if (!resetn) begin
         stalled_prev = 1'b0;
      end else begin
         if (stalled_prev && m_axis_tvalid) begin
            checks++;
            if (m_axis_tdata !== prev_data || m_axis_tuser_out_port !== prev_port) begin
               errors++;
               $display("FAIL hold_stable: data=%h port=%h required data=%h port=%h",
                        m_axis_tdata[31:0], m_axis_tuser_out_port, prev_data[31:0], prev_port);
            end
         end
         if (m_axis_tvalid && m_axis_tready) begin
            r.data = m_axis_tdata;             r.keep = m_axis_tkeep;
            r.last = m_axis_tlast;             r.inp  = m_axis_tuser_in_port;
            r.invp = m_axis_tuser_in_vport;    r.len  = m_axis_tuser_packet_length;
            r.op   = m_axis_tuser_out_port;    r.ov   = m_axis_tuser_out_vport;
            r.cyc  = cyc;
            got_q.push_back(r);
         end
         stalled_prev = m_axis_tvalid && !m_axis_tready;
         prev_data    = m_axis_tdata;
         prev_port    = m_axis_tuser_out_port;
      end
   end

   // driver: called at a negedge, returns at a negedge after the beat was accepted
   task automatic send_beat(input logic [255:0] d, input logic [31:0] k, input logic l,
                            input logic [7:0] op, input logic [7:0] ov,
                            output int acc, output int stalls);
      logic ok;
      s_axis_tdata = d;
      s_axis_tkeep = k;
      s_axis_tlast = l;
      s_axis_tuser_in_port = d[2:0];
      s_axis_tuser_in_vport = d[5:3];
      s_axis_tuser_packet_length = d[19:6];
      s_axis_tuser_out_port = op;
      s_axis_tuser_out_vport = ov;
      s_axis_tvalid = 1'b1;
      stalls = 0;
      acc = 0;
      forever begin
         #1;
         ok = s_axis_tready;
         acc = cyc;
         @(posedge clk);
         if (ok) break;
         stalls++;
         if (stalls > 200) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: tready stayed 0 for %0d cycles, required acceptance", stalls);
            break;
         end
         @(negedge clk);
      end
      @(negedge clk);
      s_axis_tvalid = 1'b0;
   endtask

   task automatic wait_got(input int n);
      int t = 0;
      while (got_q.size() < n && t < 500) begin
         @(negedge clk);
         t++;
      end
      repeat (3) @(negedge clk);
   endtask

   task automatic test_reset();
      #12;
      checks++;
      if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_tdata !== '0 ||
          m_axis_tuser_out_port !== 8'h00 || pass_count !== 0 || drop_count !== 0 ||
          fsm_state !== 2'd0) begin
         errors++;
         $display("FAIL reset_hold: tvalid=%b tready=%b port=%h pass=%0d drop=%0d state=%0d required 0,0,00,0,0,0",
                  m_axis_tvalid, s_axis_tready, m_axis_tuser_out_port, pass_count, drop_count, fsm_state);
      end
      @(negedge clk);
      resetn = 1'b1;
      #1;
      checks++;
      if (s_axis_tready !== 1'b0) begin
         errors++;
         $display("FAIL reset_release_early: tready=%b required 0", s_axis_tready);
      end
      @(negedge clk);
      #1;
      checks++;
      if (s_axis_tready !== 1'b1) begin
         errors++;
         $display("FAIL reset_release_ready: tready=%b required 1", s_axis_tready);
      end
      @(negedge clk);
   endtask

   task automatic test_pass();
      int   acc[3];
      int   st;
      rec_t r;
      got_q.delete();
      m_axis_tready = 1'b1;
      port_enable = 8'hFF;
      vport_enable = 8'hFF;
      send_beat(256'hA000, 32'hFFFF_FFFF, 1'b0, 8'h04, 8'h00, acc[0], st);
      send_beat(256'hA001, 32'hFFFF_FFFF, 1'b0, 8'h04, 8'h00, acc[1], st);
      send_beat(256'hA002, 32'h0000_00FF, 1'b1, 8'h04, 8'h00, acc[2], st);
      wait_got(3);
      checks++;
      if (got_q.size() !== 3) begin
         errors++;
         $display("FAIL pass_count_beats: got %0d beats required 3", got_q.size());
      end
      for (int i = 0; i < 3 && i < got_q.size(); i++) begin
         r = got_q[i];
         checks++;
         if (r.data !== 256'hA000 + 256'(i) || r.op !== 8'h04 || r.ov !== 8'h00 ||
             r.last !== (i == 2) || r.keep !== (i == 2 ? 32'h0000_00FF : 32'hFFFF_FFFF) ||
             r.inp !== 3'(i) || r.invp !== 3'd0 || r.len !== 14'h280) begin
            errors++;
            $display("FAIL pass_beat%0d: data=%h port=%h last=%b keep=%h len=%h required data=%h port=04",
                     i, r.data[31:0], r.op, r.last, r.keep, r.len, 32'hA000 + i);
         end
         checks++;
         if (r.cyc !== acc[i] + 1) begin
            errors++;
            $display("FAIL pass_latency%0d: out cycle %0d required %0d", i, r.cyc, acc[i] + 1);
         end
      end
      checks++;
      if (pass_count !== 8'd1 || drop_count !== 8'd0) begin
         errors++;
         $display("FAIL pass_counters: pass=%0d drop=%0d required 1,0", pass_count, drop_count);
      end
   endtask

   task automatic test_drop();
      int acc;
      int st;
      int total = 0;
      got_q.delete();
      port_enable = 8'hFB;
      m_axis_tready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         send_beat(256'hB000 + 256'(i), 32'hFFFF_FFFF, i == 2, 8'h04, 8'h00, acc, st);
         total += st;
      end
      wait_got(0);
      checks++;
      if (total !== 0 || got_q.size() !== 0) begin
         errors++;
         $display("FAIL drop_consume: stalls=%0d beats_out=%0d required 0,0", total, got_q.size());
      end
      checks++;
      if (drop_count !== 8'd1 || pass_count !== 8'd1) begin
         errors++;
         $display("FAIL drop_counters: pass=%0d drop=%0d required 1,1", pass_count, drop_count);
      end
      m_axis_tready = 1'b1;
      port_enable = 8'hFF;
   endtask

   task automatic test_dma_rule();
      int acc;
      int st;
      got_q.delete();
      port_enable = 8'hFF;
      vport_enable = 8'hF7;
      send_beat(256'hC000, 32'hFFFF_FFFF, 1'b0, 8'h02, 8'h08, acc, st);
      send_beat(256'hC001, 32'hFFFF_FFFF, 1'b1, 8'h02, 8'h08, acc, st);
      send_beat(256'hC010, 32'hFFFF_FFFF, 1'b1, 8'h03, 8'h08, acc, st);
      send_beat(256'hC020, 32'hFFFF_FFFF, 1'b1, 8'h02, 8'h01, acc, st);
      wait_got(2);
      checks++;
      if (got_q.size() !== 2) begin
         errors++;
         $display("FAIL dma_beats: got %0d beats required 2", got_q.size());
      end else begin
         checks++;
         if (got_q[0].data !== 256'hC010 || got_q[0].op !== 8'h01 || got_q[0].ov !== 8'h00) begin
            errors++;
            $display("FAIL dma_strip: data=%h port=%h vport=%h required C010,01,00",
                     got_q[0].data[31:0], got_q[0].op, got_q[0].ov);
         end
         checks++;
         if (got_q[1].data !== 256'hC020 || got_q[1].op !== 8'h02 || got_q[1].ov !== 8'h01) begin
            errors++;
            $display("FAIL dma_keep: data=%h port=%h vport=%h required C020,02,01",
                     got_q[1].data[31:0], got_q[1].op, got_q[1].ov);
         end
      end
      checks++;
      if (pass_count !== 8'd3 || drop_count !== 8'd2) begin
         errors++;
         $display("FAIL dma_counters: pass=%0d drop=%0d required 3,2", pass_count, drop_count);
      end
   endtask

   task automatic test_back_to_back();
      int   acc;
      int   st;
      int   total = 0;
      bit   done = 1'b0;
      int   first_cyc;
      logic [7:0] op;
      got_q.delete();
      exp_q.delete();
      port_enable = 8'hFF;
      vport_enable = 8'hF7;
      fork
         begin
            for (int i = 0; i < 100; i++) begin
               op = 8'h01 << (i % 8);
               exp_q.push_back({op, 24'(i)});
               send_beat(256'(i), 32'hFFFF_FFFF, 1'b1, op, 8'h01, acc, st);
            end
            done = 1'b1;
         end
         begin
            while (!done) begin
               @(negedge clk);
               m_axis_tready = 1'($urandom_range(0, 1));
            end
         end
      join
      m_axis_tready = 1'b1;
      wait_got(100);
      checks++;
      if (got_q.size() !== 100) begin
         errors++;
         $display("FAIL b2b_count: got %0d beats required 100", got_q.size());
      end
      for (int i = 0; i < got_q.size() && exp_q.size() > 0; i++) begin
         logic [31:0] e;
         e = exp_q.pop_front();
         checks++;
         if ({got_q[i].op, got_q[i].data[23:0]} !== e || got_q[i].data[255:24] !== '0) begin
            errors++;
            $display("FAIL b2b_order%0d: got port=%h data=%h required %h",
                     i, got_q[i].op, got_q[i].data[23:0], e);
         end
      end
      got_q.delete();
      for (int i = 0; i < 20; i++) begin
         send_beat(256'h100 + 256'(i), 32'hFFFF_FFFF, 1'b1, 8'h80, 8'h00, acc, st);
         total += st;
      end
      wait_got(20);
      checks++;
      if (total !== 0 || got_q.size() !== 20) begin
         errors++;
         $display("FAIL b2b_throughput: stalls=%0d beats=%0d required 0,20", total, got_q.size());
      end else begin
         first_cyc = got_q[0].cyc;
         checks++;
         if (got_q[19].cyc - first_cyc !== 19) begin
            errors++;
            $display("FAIL b2b_gapless: span=%0d cycles required 19", got_q[19].cyc - first_cyc);
         end
      end
      checks++;
      if (pass_count !== 8'd123) begin
         errors++;
         $display("FAIL b2b_pass_count: pass=%0d required 123", pass_count);
      end
   endtask

   task automatic test_enable_change();
      int acc;
      int st;
      got_q.delete();
      m_axis_tready = 1'b1;
      port_enable = 8'hFF;
      vport_enable = 8'hFF;
      send_beat(256'hD000, 32'hFFFF_FFFF, 1'b0, 8'h04, 8'h00, acc, st);
      port_enable = 8'h00;
      send_beat(256'hD001, 32'hFFFF_FFFF, 1'b0, 8'h04, 8'h00, acc, st);
      send_beat(256'hD002, 32'hFFFF_FFFF, 1'b1, 8'h04, 8'h00, acc, st);
      send_beat(256'hD010, 32'hFFFF_FFFF, 1'b0, 8'h04, 8'h00, acc, st);
      send_beat(256'hD011, 32'hFFFF_FFFF, 1'b1, 8'h04, 8'h00, acc, st);
      wait_got(3);
      checks++;
      if (got_q.size() !== 3) begin
         errors++;
         $display("FAIL enchg_beats: got %0d beats required 3", got_q.size());
      end else begin
         checks++;
         if (got_q[2].data !== 256'hD002 || got_q[2].op !== 8'h04 || got_q[1].op !== 8'h04) begin
            errors++;
            $display("FAIL enchg_latched: last data=%h port=%h required D002,04",
                     got_q[2].data[31:0], got_q[2].op);
         end
      end
      checks++;
      if (pass_count !== 8'd124 || drop_count !== 8'd3) begin
         errors++;
         $display("FAIL enchg_counters: pass=%0d drop=%0d required 124,3", pass_count, drop_count);
      end
      port_enable = 8'hFF;
   endtask

   task automatic test_reset_mid();
      int acc;
      int st;
      m_axis_tready = 1'b0;
      port_enable = 8'hFF;
      vport_enable = 8'hFF;
      send_beat(256'hE000, 32'hFFFF_FFFF, 1'b0, 8'h04, 8'h00, acc, st);
      send_beat(256'hE001, 32'hFFFF_FFFF, 1'b0, 8'h04, 8'h00, acc, st);
      resetn = 1'b0;
      #1;
      checks++;
      if (m_axis_tvalid !== 1'b0 || s_axis_tready !== 1'b0 || m_axis_tdata !== '0 ||
          m_axis_tuser_out_port !== 8'h00 || pass_count !== 0 || drop_count !== 0) begin
         errors++;
         $display("FAIL midreset_clear: tvalid=%b tready=%b data=%h pass=%0d drop=%0d required all 0",
                  m_axis_tvalid, s_axis_tready, m_axis_tdata[31:0], pass_count, drop_count);
      end
      @(negedge clk);
      resetn = 1'b1;
      got_q.delete();
      m_axis_tready = 1'b1;
      send_beat(256'hE100, 32'hFFFF_FFFF, 1'b1, 8'h10, 8'h00, acc, st);
      wait_got(1);
      checks++;
      if (got_q.size() !== 1) begin
         errors++;
         $display("FAIL midreset_beats: got %0d beats required 1", got_q.size());
      end else begin
         checks++;
         if (got_q[0].data !== 256'hE100 || got_q[0].op !== 8'h10) begin
            errors++;
            $display("FAIL midreset_head: data=%h port=%h required E100,10",
                     got_q[0].data[31:0], got_q[0].op);
         end
      end
      checks++;
      if (pass_count !== 8'd1 || drop_count !== 8'd0) begin
         errors++;
         $display("FAIL midreset_counters: pass=%0d drop=%0d required 1,0", pass_count, drop_count);
      end
   endtask

   task automatic test_saturate();
      int acc;
      int st;
      m_axis_tready = 1'b1;
      port_enable = 8'h00;
      for (int i = 0; i < 300; i++)
         send_beat(256'(i), 32'hFFFF_FFFF, 1'b1, 8'h01, 8'h00, acc, st);
      port_enable = 8'hFF;
      for (int i = 0; i < 300; i++)
         send_beat(256'(i), 32'hFFFF_FFFF, 1'b1, 8'h01, 8'h00, acc, st);
      repeat (3) @(negedge clk);
      checks++;
      if (drop_count !== 8'hFF || pass_count !== 8'hFF) begin
         errors++;
         $display("FAIL saturate: pass=%0d drop=%0d required 255,255", pass_count, drop_count);
      end
      got_q.delete();
   endtask

   initial begin
      test_reset();
      test_pass();
      test_drop();
      test_dma_rule();
      test_back_to_back();
      test_enable_change();
      test_reset_mid();
      test_saturate();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
